// File: rtl/time_setter.sv
// time_setter: button-driven HH:MM entry block.
//   Debounces three raw push-buttons and runs a digit-by-digit edit FSM.
//   On commit it presents binary hours/minutes together with a one-cycle
//   load strobe for the timekeeping counter.
//
// Ports:
//   clock, reset_n           system clock (rising edge), async active-low reset
//   btn_mode/next/up         raw asynchronous buttons (enter/abort, advance/commit, increment)
//   cur_ore, cur_minute      current time, sampled on entering edit
//   ore, minute              last committed time (registered)
//   time_load                one-cycle strobe, ore/minute valid in the same cycle
//   editing, cursor          edit status and selected digit (0=Ht 1=Hu 2=Mt 3=Mu)
//
// Optional build macro TIME_SETTER_AUTO_REPEAT_EN: auto-repeat on a held
// btn_up while editing, one extra increment every REPEAT_CYCLES cycles.
//
// state  | meaning
// IDLE   | waiting for a mode press; next/up ignored
// EDIT   | digit entry; cursor selects the digit under edit
// COMMIT | single cycle, new time presented with time_load high

module time_setter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic [4:0] cur_ore,
    input  logic [5:0] cur_minute,
    output logic [4:0] ore,
    output logic [5:0] minute,
    output logic       time_load,
    output logic       editing,
    output logic [1:0] cursor
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, EDIT = 2'd1, COMMIT = 2'd2} state_t;

    function automatic logic [3:0] mul10_4(input logic [3:0] x);
        return (x << 3) + (x << 1);
    endfunction

    function automatic logic [4:0] mul10_5(input logic [4:0] x);
        return (x << 3) + (x << 1);
    endfunction

    function automatic logic [5:0] mul10_6(input logic [5:0] x);
        return (x << 3) + (x << 1);
    endfunction

    // Button path: index 0=mode, 1=next, 2=up
    logic [2:0]    raw, sync_a, sync_b, level, level_d, press;
    logic [DW-1:0] db_cnt [3];

    assign raw = {btn_up, btn_next, btn_mode};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a  <= '0;
            sync_b  <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            level_d <= level;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = level & ~level_d;

    state_t     state, state_nxt;
    logic [1:0] cursor_nxt;
    logic [1:0] ht, ht_n;
    logic [3:0] hu, hu_n;
    logic [2:0] mt, mt_n;
    logic [3:0] mu, mu_n;
    logic [4:0] ore_n;
    logic [5:0] minute_n;
    logic       mode_p, next_p, up_p;

    assign mode_p = press[0];
    assign next_p = press[1];

`ifdef TIME_SETTER_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    logic [RW-1:0] rpt_cnt;
    logic          rpt_clr, rpt_fire;

    // The press cycle sees rpt_cnt==0, so the first repeat lands exactly
    // REPEAT_CYCLES later; restarting at 1 keeps the period constant.
    assign rpt_clr  = (state != EDIT) || (state_nxt != EDIT) || !level[2] ||
                      (cursor_nxt != cursor);
    assign rpt_fire = (state == EDIT) && level[2] && (rpt_cnt == RW'(REPEAT_CYCLES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      rpt_cnt <= '0;
        else if (rpt_clr)  rpt_cnt <= '0;
        else if (rpt_fire) rpt_cnt <= RW'(1);
        else               rpt_cnt <= rpt_cnt + 1'b1;
    end

    assign up_p = press[2] | rpt_fire;
`else
    assign up_p = press[2];
`endif

    // Digit split of the live time; out-of-range fields load as 00.
    // Units are taken mod 16, which is exact since the result is below 10.
    logic [4:0] h_src;
    logic [5:0] m_src;
    logic [1:0] h_tens;
    logic [2:0] m_tens;
    logic [3:0] h_units, m_units;

    assign h_src   = (cur_ore > 5'd23)    ? '0 : cur_ore;
    assign m_src   = (cur_minute > 6'd59) ? '0 : cur_minute;
    assign h_tens  = (h_src >= 5'd20) ? 2'd2 : (h_src >= 5'd10) ? 2'd1 : 2'd0;
    assign m_tens  = (m_src >= 6'd50) ? 3'd5 : (m_src >= 6'd40) ? 3'd4 :
                     (m_src >= 6'd30) ? 3'd3 : (m_src >= 6'd20) ? 3'd2 :
                     (m_src >= 6'd10) ? 3'd1 : 3'd0;
    assign h_units = h_src[3:0] - mul10_4({2'b00, h_tens});
    assign m_units = m_src[3:0] - mul10_4({1'b0, m_tens});

    always_comb begin
        state_nxt  = state;
        cursor_nxt = cursor;
        ht_n       = ht;
        hu_n       = hu;
        mt_n       = mt;
        mu_n       = mu;
        ore_n      = ore;
        minute_n   = minute;
        case (state)
            IDLE: begin
                if (mode_p) begin
                    state_nxt  = EDIT;
                    cursor_nxt = 2'd0;
                    ht_n       = h_tens;
                    hu_n       = h_units;
                    mt_n       = m_tens;
                    mu_n       = m_units;
                end
            end
            EDIT: begin
                if (mode_p) begin
                    state_nxt  = IDLE;
                    cursor_nxt = 2'd0;
                end else if (next_p) begin
                    if (cursor == 2'd3) begin
                        state_nxt  = COMMIT;
                        cursor_nxt = 2'd0;
                        ore_n      = mul10_5({3'b000, ht}) + {1'b0, hu};
                        minute_n   = mul10_6({3'b000, mt}) + {2'b00, mu};
                    end else begin
                        cursor_nxt = cursor + 2'd1;
                    end
                end else if (up_p) begin
                    case (cursor)
                        2'd0: begin
                            ht_n = (ht == 2'd2) ? 2'd0 : ht + 2'd1;
                            if (ht_n == 2'd2 && hu > 4'd3) hu_n = 4'd3;
                        end
                        2'd1: begin
                            if (ht == 2'd2) hu_n = (hu >= 4'd3) ? 4'd0 : hu + 4'd1;
                            else            hu_n = (hu == 4'd9) ? 4'd0 : hu + 4'd1;
                        end
                        2'd2:    mt_n = (mt == 3'd5) ? 3'd0 : mt + 3'd1;
                        default: mu_n = (mu == 4'd9) ? 4'd0 : mu + 4'd1;
                    endcase
                end
            end
            COMMIT: begin
                state_nxt  = IDLE;
                cursor_nxt = 2'd0;
            end
            default: begin
                state_nxt  = IDLE;
                cursor_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cursor    <= '0;
            ht        <= '0;
            hu        <= '0;
            mt        <= '0;
            mu        <= '0;
            ore       <= '0;
            minute    <= '0;
            time_load <= 1'b0;
            editing   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cursor    <= cursor_nxt;
            ht        <= ht_n;
            hu        <= hu_n;
            mt        <= mt_n;
            mu        <= mu_n;
            ore       <= ore_n;
            minute    <= minute_n;
            time_load <= (state_nxt == COMMIT);
            editing   <= (state_nxt == EDIT);
        end
    end

endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: randomized and directed bench for time_setter with a
// digit-level reference model of the edit session.
`timescale 1ns/1ps

module tb_time_setter;

    localparam int D        = 4;
    localparam int R        = 8;
    localparam int HOLD_ON  = D + 2;   // long enough to debounce, shorter than R
    localparam int HOLD_OFF = D + 6;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0;
    logic [4:0] cur_ore = '0;
    logic [5:0] cur_minute = '0;
    logic [4:0] ore;
    logic [5:0] minute;
    logic       time_load, editing;
    logic [1:0] cursor;

    always #5 clock = ~clock;

    time_setter #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clock(clock), .reset_n(reset_n),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up),
        .cur_ore(cur_ore), .cur_minute(cur_minute),
        .ore(ore), .minute(minute), .time_load(time_load),
        .editing(editing), .cursor(cursor)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int loads    = 0;

    // Reference model: edit flag, cursor, four decimal digits, committed time
    int m_ed, m_cur, m_ore, m_min, m_loads;
    int m_d [4];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    always @(negedge clock) begin
        if (time_load) begin
            loads++;
            check("editing_at_load", editing, 0);
            check("cursor_at_load", cursor, 0);
        end
    end

    task automatic model_reset();
        m_ed = 0; m_cur = 0; m_ore = 0; m_min = 0;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
    endtask

    task automatic model_op(input int op);  // 0=mode 1=next 2=up
        int h, m, lim;
        case (op)
            0: begin
                if (m_ed == 0) begin
                    h = (cur_ore > 23) ? 0 : int'(cur_ore);
                    m = (cur_minute > 59) ? 0 : int'(cur_minute);
                    m_d[0] = h / 10; m_d[1] = h % 10;
                    m_d[2] = m / 10; m_d[3] = m % 10;
                    m_ed = 1;
                end else begin
                    m_ed = 0;
                end
                m_cur = 0;
            end
            1: if (m_ed == 1) begin
                if (m_cur < 3) m_cur++;
                else begin
                    m_ore = m_d[0] * 10 + m_d[1];
                    m_min = m_d[2] * 10 + m_d[3];
                    m_loads++;
                    m_ed = 0; m_cur = 0;
                end
            end
            default: if (m_ed == 1) begin
                case (m_cur)
                    0: begin
                        m_d[0] = (m_d[0] + 1) % 3;
                        if (m_d[0] == 2 && m_d[1] > 3) m_d[1] = 3;
                    end
                    1: begin
                        lim = (m_d[0] == 2) ? 4 : 10;
                        m_d[1] = (m_d[1] + 1) % lim;
                    end
                    2: m_d[2] = (m_d[2] + 1) % 6;
                    default: m_d[3] = (m_d[3] + 1) % 10;
                endcase
            end
        endcase
    endtask

    task automatic drive(input logic [2:0] mask, input int on_cycles, input int off_cycles);
        {btn_up, btn_next, btn_mode} = mask;
        repeat (on_cycles) @(posedge clock);
        #1 {btn_up, btn_next, btn_mode} = 3'b000;
        repeat (off_cycles) @(posedge clock);
        #1;
    endtask

    task automatic press(input int op);
        drive(3'b001 << op, HOLD_ON, HOLD_OFF);
        model_op(op);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".editing"}, editing, m_ed);
        check({tag, ".cursor"}, cursor, m_cur);
        check({tag, ".ore"}, ore, m_ore);
        check({tag, ".minute"}, minute, m_min);
        check({tag, ".loads"}, loads, m_loads);
    endtask

    initial begin
        int nops, r, saved_loads, ups;
        model_reset();
        m_loads = 0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.ore", ore, 0);
        check("reset.minute", minute, 0);
        check("reset.time_load", time_load, 0);
        check("reset.editing", editing, 0);
        check("reset.cursor", cursor, 0);
        reset_n = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        check_state("idle50");

        // Straight pass-through commit
        cur_ore = 5'd17; cur_minute = 6'd42;
        press(0);
        check_state("enter_17_42");
        for (int i = 0; i < 4; i++) press(1);
        check_state("commit_17_42");
        check("commit_17_42.ore_const", ore, 17);
        check("commit_17_42.min_const", minute, 42);

        // Hours tens to 2 clamps units to 3, then units wraps 3->0
        cur_ore = 5'd19; cur_minute = 6'd59;
        press(0); press(2); press(1); press(2);
        check_state("clamp_edit");
        for (int i = 0; i < 3; i++) press(1);
        check_state("clamp_commit");
        check("clamp_commit.ore_const", ore, 20);
        check("clamp_commit.min_const", minute, 59);

        // Short glitches on up are filtered
        cur_ore = 5'd5; cur_minute = 6'd7;
        press(0); press(1); press(1); press(1);
        for (int i = 0; i < 3; i++) drive(3'b100, D - 1, HOLD_OFF);
        check_state("glitch");
        press(1);
        check_state("glitch_commit");

        // Abort mid-edit keeps previous committed time
        cur_ore = 5'd11; cur_minute = 6'd11;
        press(0); press(2); press(1); press(2);
        press(0);
        check_state("abort");

        // next beats up in the same cycle
        press(0);
        drive(3'b110, HOLD_ON, HOLD_OFF);
        model_op(1);
        check_state("next_over_up");
        // mode beats next in the same cycle
        drive(3'b011, HOLD_ON, HOLD_OFF);
        model_op(0);
        check_state("mode_over_next");

        // Randomized sessions, including out-of-range live time
        for (int s = 0; s < 25; s++) begin
            cur_ore = 5'($urandom_range(0, 31));
            cur_minute = 6'($urandom_range(0, 63));
            if (m_ed == 0) press(0);
            nops = $urandom_range(4, 14);
            for (int k = 0; k < nops; k++) begin
                r = $urandom_range(0, 9);
                press(r == 0 ? 0 : (r < 5 ? 1 : 2));
                if ($urandom_range(0, 2) == 0) begin
                    cur_ore = 5'($urandom_range(0, 31));
                    cur_minute = 6'($urandom_range(0, 63));
                end
            end
            check_state("random");
        end

        // Make sure a nonzero time is committed, then reset mid-edit
        if (m_ed == 1) press(0);
        cur_ore = 5'd23; cur_minute = 6'd58;
        press(0);
        for (int i = 0; i < 4; i++) press(1);
        check_state("pre_reset_commit");
        press(0); press(1);
        saved_loads = loads;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_reset.ore", ore, 0);
        check("async_reset.minute", minute, 0);
        check("async_reset.editing", editing, 0);
        check("async_reset.cursor", cursor, 0);
        check("async_reset.time_load", time_load, 0);
        check("async_reset.loads", loads, saved_loads);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_state("after_reset");

        // Held up button on minutes units
        cur_ore = 5'd0; cur_minute = 6'd0;
        press(0); press(1); press(1); press(1);
`ifdef TIME_SETTER_AUTO_REPEAT_EN
        ups = 4;
`else
        ups = 1;
`endif
        drive(3'b100, D + 2 + 1 + 3 * R - 1, HOLD_OFF);
        for (int i = 0; i < ups; i++) model_op(2);
        press(1);
        check_state("held_up");
        check("held_up.minute_const", minute, ups);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
